// File: rtl/bnn_seq_driver.sv
// bnn_seq_driver
//   Sequences one sequential BNN classifier core from a valid/ready stream of
//   packed feature vectors. An accepted vector is held on core_data, the core is
//   pulsed through reset, the driver waits the fixed inference latency LAT, then
//   captures klass and offers C-1-klass with a running sequence index on a
//   valid/ready result stream.
//
//   Optional build macro: BNN_DRV_CHECK_EN adds an expected-class input captured
//   with each vector, a per-result mismatch flag and a saturating error counter.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  feature vector handshake (in_ready decoded from state)
//   in_data            packed feature vector, B*N bits
//   core_data          registered vector to the core data input
//   core_rst           registered reset to the core
//   core_klass         class index from the core
//   res_valid/ready    result handshake
//   res_klass          remapped class C-1-core_klass
//   res_index          sequence number of the result (wraps at 2^IW)
//   busy               driver is not idle
//   in_expect          (BNN_DRV_CHECK_EN) expected class for in_data
//   res_mismatch       (BNN_DRV_CHECK_EN) res_klass differs from expectation
//   err_count          (BNN_DRV_CHECK_EN) saturating count of handshaked mismatches
module bnn_seq_driver #(
  parameter  int N   = 11,
  parameter  int B   = 4,
  parameter  int M   = 40,
  parameter  int C   = 6,
  parameter  int LAT = N + M,
  parameter  int IW  = 8,
  localparam int KW  = $clog2(C),
  localparam int DW  = B * N,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] core_data,
  output logic          core_rst,
  input  logic [KW-1:0] core_klass,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [KW-1:0] res_klass,
  output logic [IW-1:0] res_index,
  output logic          busy
`ifdef BNN_DRV_CHECK_EN
  ,
  input  logic [KW-1:0] in_expect,
  output logic          res_mismatch,
  output logic [IW-1:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, CRST, RUN, OUT} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          core_rst_q, core_rst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [KW-1:0] klass_q, klass_d;
  logic [IW-1:0] index_q, index_d;
`ifdef BNN_DRV_CHECK_EN
  logic [KW-1:0] expect_q, expect_d;
  logic          mm_q, mm_d;
  logic [IW-1:0] err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    klass_d  = klass_q;
    index_d  = index_q;
`ifdef BNN_DRV_CHECK_EN
    expect_d = expect_q;
    mm_d     = mm_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
`ifdef BNN_DRV_CHECK_EN
          expect_d = in_expect;
`endif
          state_d  = CRST;
        end
      end
      CRST: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAT - 1)) begin
          // Class order of the core is reversed relative to the label space.
          klass_d = KW'(C - 1) - core_klass;
          valid_d = 1'b1;
`ifdef BNN_DRV_CHECK_EN
          mm_d    = (klass_d != expect_q);
`endif
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          index_d = index_q + IW'(1);
`ifdef BNN_DRV_CHECK_EN
          if (mm_q && (err_q != {IW{1'b1}})) err_d = err_q + IW'(1);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Core is held in reset while idle and for the single CRST cycle, so it
    // sees a reset edge with the new vector already stable on its data input.
    core_rst_d = (state_d == IDLE) || (state_d == CRST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      klass_q    <= '0;
      index_q    <= '0;
`ifdef BNN_DRV_CHECK_EN
      expect_q   <= '0;
      mm_q       <= 1'b0;
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      klass_q    <= klass_d;
      index_q    <= index_d;
`ifdef BNN_DRV_CHECK_EN
      expect_q   <= expect_d;
      mm_q       <= mm_d;
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign core_data = data_q;
  assign core_rst  = core_rst_q;
  assign res_valid = valid_q;
  assign res_klass = klass_q;
  assign res_index = index_q;
`ifdef BNN_DRV_CHECK_EN
  assign res_mismatch = mm_q;
  assign err_count    = err_q;
`endif

endmodule

// File: tb/tb_bnn_seq_driver.sv
// Testbench for bnn_seq_driver: behavioural core stub, timeline-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_bnn_seq_driver;
  localparam int N   = 11;
  localparam int B   = 4;
  localparam int M   = 40;
  localparam int C   = 6;
  localparam int LAT = N + M;
  localparam int IW  = 8;
  localparam int KW  = $clog2(C);
  localparam int DW  = B * N;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] core_data;
  logic          core_rst;
  logic [KW-1:0] core_klass;
  logic          res_valid;
  logic          res_ready;
  logic [KW-1:0] res_klass;
  logic [IW-1:0] res_index;
  logic          busy;
  logic [KW-1:0] in_expect;
`ifdef BNN_DRV_CHECK_EN
  logic          res_mismatch;
  logic [IW-1:0] err_count;
`endif

  bnn_seq_driver #(.N(N), .B(B), .M(M), .C(C), .LAT(LAT), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .core_data  (core_data),
    .core_rst   (core_rst),
    .core_klass (core_klass),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_klass  (res_klass),
    .res_index  (res_index),
    .busy       (busy)
`ifdef BNN_DRV_CHECK_EN
    ,
    .in_expect    (in_expect),
    .res_mismatch (res_mismatch),
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Core stub: counts cycles since its reset was released and only presents
  // the programmed class once LAT cycles have elapsed; before that it shows a
  // different (wrong) class so an early capture is visible.
  logic [KW-1:0] stub_k;
  int scyc = 0;
  always @(posedge clk) begin
    if (core_rst) scyc <= 0;
    else if (scyc < 100000) scyc <= scyc + 1;
  end
  assign core_klass = (scyc >= LAT - 1) ? stub_k :
                      ((stub_k == KW'(C - 1)) ? '0 : stub_k + KW'(1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Reference model: a transaction is described by the edge it was accepted on;
  // all driver outputs follow from the distance to that edge.
  bit            armed = 0;
  bit            m_idle = 1;
  int            m_acc = 0;
  int            md = 0;
  logic [DW-1:0] m_data = '0;
  logic [KW-1:0] m_klass = '0;
  logic [IW-1:0] m_index = '0;
  logic [KW-1:0] m_exp = '0;
  bit            m_mm = 0;
  logic [IW-1:0] m_err = '0;

  always @(negedge clk) begin
    md = edge_n - m_acc;
    if (armed) begin
      if (m_idle) begin
        check("m_in_ready", in_ready, 1);
        check("m_busy", busy, 0);
        check("m_core_rst", core_rst, 1);
        check("m_res_valid", res_valid, 0);
      end else begin
        check("m_in_ready", in_ready, 0);
        check("m_busy", busy, 1);
        check("m_core_rst", core_rst, (md == 0));
        check("m_res_valid", res_valid, (md >= LAT + 1));
      end
      check("m_core_data", core_data, m_data);
      check("m_res_index", res_index, m_index);
      check("m_res_klass", res_klass, m_klass);
`ifdef BNN_DRV_CHECK_EN
      check("m_err_count", err_count, m_err);
      if (!m_idle && md >= LAT + 1) check("m_res_mismatch", res_mismatch, m_mm);
`endif
    end
    if (rst) begin
      armed   = 1;
      m_idle  = 1;
      m_data  = '0;
      m_klass = '0;
      m_index = '0;
      m_exp   = '0;
      m_mm    = 0;
      m_err   = '0;
    end else if (armed) begin
      if (m_idle) begin
        if (in_valid) begin
          m_idle = 0;
          m_acc  = edge_n + 1;
          m_data = in_data;
          m_exp  = in_expect;
        end
      end else if (md + 1 == LAT + 1) begin
        m_klass = KW'(C - 1 - int'(stub_k));
        m_mm    = (m_klass != m_exp);
      end else if (md >= LAT + 1 && res_ready) begin
        m_idle  = 1;
        m_index = m_index + IW'(1);
        if (m_mm && m_err != {IW{1'b1}}) m_err = m_err + IW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector and return the edge it was accepted on; in_valid stays high.
  task automatic send(input logic [DW-1:0] v, input logic [KW-1:0] ex, output int acc_e);
    bit rdy;
    in_data   = v;
    in_expect = ex;
    in_valid  = 1'b1;
    acc_e     = -1;
    for (int i = 0; i < 200; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc_e = edge_n;
        break;
      end
    end
    if (acc_e < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_result(output int ve);
    ve = -1;
    for (int i = 0; i < 200; i++) begin
      if (res_valid === 1'b1) begin
        ve = edge_n;
        break;
      end
      tick();
    end
    if (ve < 0) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got no res_valid expected res_valid within 200 cycles");
    end
  endtask

  logic [DW-1:0] vec [5];
  int acc [5];
  int a, a2, ve, h;

  initial begin
    vec[0] = 44'h46012229a22;
    vec[1] = 44'h58022538633;
    vec[2] = 44'h57122338733;
    vec[3] = 44'h92912439523;
    vec[4] = 44'h46012229a22;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_data = '0; in_expect = '0; stub_k = 3'd2;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_core_rst", core_rst, 1);
    check("reset_res_valid", res_valid, 0);
    check("reset_core_data", core_data, 0);
    check("reset_busy", busy, 0);

    // Single inference, klass 2 -> 3, latency 52 from the accept edge.
    res_ready = 1'b1;
    send(vec[0], 3'd3, a);
    in_valid = 1'b0;
    check("t1_core_rst_E0", core_rst, 1);
    check("t1_core_data", core_data, 44'h46012229a22);
    tick();
    check("t1_core_rst_E1", core_rst, 0);
    wait_result(ve);
    check("t1_latency", ve - a, 52);
    check("t1_res_klass", res_klass, 3);
    check("t1_res_index", res_index, 0);
    tick();

    // Five back-to-back vectors after a fresh reset.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) send(vec[i], 3'd3, acc[i]);
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) check("t2_accept_spacing", acc[i] - acc[i-1], 54);
    wait_result(ve);
    check("t2_last_index", res_index, 4);
    tick();
    check("t2_index_after5", res_index, 5);

    // Result back-pressure with a competing input offer.
    res_ready = 1'b0;
    send(vec[1], 3'd3, a);
    in_data = vec[2];
    wait_result(ve);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_in_ready_held", in_ready, 0);
      check("t3_res_valid_held", res_valid, 1);
      check("t3_core_data_held", core_data, 44'h58022538633);
    end
    res_ready = 1'b1;
    h = edge_n;
    send(vec[2], 3'd3, a2);
    in_valid = 1'b0;
    check("t3_accept_after_hs", a2 - h, 2);
    wait_result(ve);
    tick();

    // Reset in the middle of RUN (cnt = 20) drops the inference.
    send(vec[3], 3'd3, a);
    in_valid = 1'b0;
    while (edge_n < a + 21) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_res_valid", res_valid, 0);
    check("t4_core_rst", core_rst, 1);
    check("t4_core_data", core_data, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_res_index", res_index, 0);
    repeat (60) tick();
    check("t4_no_result", res_valid, 0);
    send(vec[4], 3'd3, a);
    in_valid = 1'b0;
    wait_result(ve);
    check("t4_next_index", res_index, 0);
    tick();

    // Remap boundaries.
    stub_k = 3'd0;
    send(vec[0], 3'd5, a);
    in_valid = 1'b0;
    wait_result(ve);
    check("t5_klass0", res_klass, 5);
    tick();
    stub_k = 3'd5;
    send(vec[1], 3'd0, a);
    in_valid = 1'b0;
    wait_result(ve);
    check("t5_klass5", res_klass, 0);
    tick();

`ifdef BNN_DRV_CHECK_EN
    stub_k = 3'd2;
    send(vec[0], 3'd3, a);
    in_valid = 1'b0;
    wait_result(ve);
    check("t6_match", res_mismatch, 0);
    tick();
    send(vec[0], 3'd4, a);
    in_valid = 1'b0;
    wait_result(ve);
    check("t6_mismatch", res_mismatch, 1);
    check("t6_err_before", err_count, 0);
    tick();
    check("t6_err_after", err_count, 1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
